// File: rtl/sdram_mon_pkg.sv
// Shared types for the SDRAM init monitor: decoded commands, FSM states, error causes
// and the counter-width helper.
package sdram_mon_pkg;

  typedef enum logic [2:0] {
    CmdInhibit = 3'd0,
    CmdNop     = 3'd1,
    CmdPre     = 3'd2,
    CmdAref    = 3'd3,
    CmdLmr     = 3'd4,
    CmdOther   = 3'd5
  } cmd_e;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StWait = 3'd1,
    StPre  = 3'd2,
    StAref = 3'd3,
    StMrs  = 3'd4,
    StDone = 3'd5,
    StErr  = 3'd6
  } state_e;

  localparam logic [2:0] ErrNone = 3'd0;
  localparam logic [2:0] ErrWait = 3'd1;
  localparam logic [2:0] ErrPre  = 3'd2;
  localparam logic [2:0] ErrAref = 3'd3;
  localparam logic [2:0] ErrMrs  = 3'd4;
  localparam logic [2:0] ErrRef  = 3'd5;

  // Width of a counter that must hold 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/sdram_cmd_decode.sv
// Decodes the SDRAM command pins into a command enum; unknown pin values fall out as CmdOther.
module sdram_cmd_decode
  import sdram_mon_pkg::*;
(
  input  logic cs_n,
  input  logic ras_n,
  input  logic cas_n,
  input  logic we_n,
  output cmd_e cmd
);

  always_comb begin
    cmd = CmdOther;
    // An X/Z on cs_n fails this test and then matches no case item below.
    if (cs_n == 1'b1) begin
      cmd = CmdInhibit;
    end else begin
      case ({cs_n, ras_n, cas_n, we_n})
        4'b0111: cmd = CmdNop;
        4'b0010: cmd = CmdPre;
        4'b0001: cmd = CmdAref;
        4'b0000: cmd = CmdLmr;
        default: cmd = CmdOther;
      endcase
    end
  end

endmodule

// File: rtl/sdram_init_monitor.sv
// Watches the SDRAM power-up command sequence and flags ordering violations.
// Define SDRAM_MON_REF_WDOG_EN to build the post-init refresh-interval watchdog.
module sdram_init_monitor
  import sdram_mon_pkg::*;
#(
  parameter int unsigned INIT_NOP_CYCLES = 10000,
  parameter int unsigned NUM_AREF        = 2,
  parameter int unsigned REF_INTERVAL    = 1560,
  parameter int unsigned ERR_CNT_W       = 8
) (
  input  logic                 sdram_clk,
  input  logic                 sdram_resetn,
  input  logic                 sdram_en,
  input  logic                 sdram_cs_n,
  input  logic                 sdram_ras_n,
  input  logic                 sdram_cas_n,
  input  logic                 sdram_we_n,
  output logic                 init_done,
  output logic                 init_err,
  output logic                 ref_err,
  output logic [2:0]           err_code,
  output logic [ERR_CNT_W-1:0] err_count,
  output logic [2:0]           mon_state
);

  localparam int unsigned WaitW = cnt_w(INIT_NOP_CYCLES);
  localparam int unsigned RefW  = cnt_w(NUM_AREF);

  cmd_e             cmd;
  state_e           state;
  logic             en_q;
  logic             armed;
  logic [WaitW-1:0] wait_cnt;
  logic [RefW-1:0]  ref_cnt;
  logic             idle_cmd;
  logic             en_rise;
  logic             fault;
  logic [2:0]       fault_code;
  logic             ref_fault;

  sdram_cmd_decode u_dec (
    .cs_n  (sdram_cs_n),
    .ras_n (sdram_ras_n),
    .cas_n (sdram_cas_n),
    .we_n  (sdram_we_n),
    .cmd   (cmd)
  );

  assign idle_cmd  = (cmd == CmdInhibit) || (cmd == CmdNop);
  // armed blocks a rise until sdram_en has been seen low after reset release.
  assign en_rise   = sdram_en && !en_q && armed;
  assign mon_state = state;

  always_comb begin
    fault      = 1'b0;
    fault_code = ErrNone;
    if (sdram_en) begin
      case (state)
        StWait: if (!idle_cmd) begin fault = 1'b1; fault_code = ErrWait; end
        StPre:  if (!idle_cmd && cmd != CmdPre) begin fault = 1'b1; fault_code = ErrPre; end
        StAref: if (!idle_cmd && cmd != CmdAref) begin fault = 1'b1; fault_code = ErrAref; end
        StMrs:  if (!idle_cmd && cmd != CmdLmr) begin fault = 1'b1; fault_code = ErrMrs; end
        default: ;
      endcase
    end
  end

`ifdef SDRAM_MON_REF_WDOG_EN
  localparam int unsigned IntW = cnt_w(REF_INTERVAL);
  logic [IntW-1:0] int_cnt;
  logic            ref_err_q;

  assign ref_err   = ref_err_q;
  // A refresh landing on the violation cycle wins.
  assign ref_fault = sdram_en && (state == StDone) && (cmd != CmdAref) &&
                     (int_cnt == IntW'(REF_INTERVAL - 1));
`else
  assign ref_err   = 1'b0;
  assign ref_fault = 1'b0;
`endif

  always_ff @(posedge sdram_clk or negedge sdram_resetn) begin
    if (!sdram_resetn) begin
      state     <= StIdle;
      en_q      <= 1'b0;
      armed     <= 1'b0;
      wait_cnt  <= '0;
      ref_cnt   <= '0;
      init_done <= 1'b0;
      init_err  <= 1'b0;
      err_code  <= ErrNone;
      err_count <= '0;
`ifdef SDRAM_MON_REF_WDOG_EN
      int_cnt   <= '0;
      ref_err_q <= 1'b0;
`endif
    end else begin
      en_q <= sdram_en;
      if (!sdram_en) armed <= 1'b1;

      if (fault || ref_fault) begin
        err_code <= fault ? fault_code : ErrRef;
        if (err_count != {ERR_CNT_W{1'b1}}) err_count <= err_count + ERR_CNT_W'(1);
      end

      if (!sdram_en) begin
        state     <= StIdle;
        wait_cnt  <= '0;
        ref_cnt   <= '0;
        init_done <= 1'b0;
`ifdef SDRAM_MON_REF_WDOG_EN
        int_cnt   <= '0;
`endif
      end else if (fault) begin
        state    <= StErr;
        init_err <= 1'b1;
      end else begin
        case (state)
          StIdle: if (en_rise) state <= StWait;
          StWait: begin
            if (wait_cnt == WaitW'(INIT_NOP_CYCLES - 1)) state <= StPre;
            else wait_cnt <= wait_cnt + WaitW'(1);
          end
          StPre: if (cmd == CmdPre) state <= StAref;
          StAref: begin
            if (cmd == CmdAref) begin
              if (ref_cnt == RefW'(NUM_AREF - 1)) state <= StMrs;
              else ref_cnt <= ref_cnt + RefW'(1);
            end
          end
          StMrs: begin
            if (cmd == CmdLmr) begin
              state     <= StDone;
              init_done <= 1'b1;
            end
          end
          StDone: begin
`ifdef SDRAM_MON_REF_WDOG_EN
            if (cmd == CmdAref) begin
              int_cnt <= '0;
            end else if (ref_fault) begin
              int_cnt   <= '0;
              ref_err_q <= 1'b1;
            end else begin
              int_cnt <= int_cnt + IntW'(1);
            end
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sdram_init_monitor.sv
// Directed bench for sdram_init_monitor, with a second 2-bit-counter instance for saturation.
module tb_sdram_init_monitor;

  localparam logic [3:0] INH  = 4'b1111;
  localparam logic [3:0] NOP  = 4'b0111;
  localparam logic [3:0] PRE  = 4'b0010;
  localparam logic [3:0] AREF = 4'b0001;
  localparam logic [3:0] LMR  = 4'b0000;
  localparam logic [3:0] RD   = 4'b0101;

  logic       clk = 1'b0;
  logic       resetn;
  logic       en;
  logic       cs_n, ras_n, cas_n, we_n;
  logic       init_done, init_err, ref_err;
  logic [2:0] err_code, mon_state;
  logic [7:0] err_count;
  logic       s_done, s_ierr, s_rerr;
  logic [2:0] s_code, s_state;
  logic [1:0] s_count;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  always #5 clk = ~clk;

  sdram_init_monitor #(
    .INIT_NOP_CYCLES (8),
    .NUM_AREF        (2),
    .REF_INTERVAL    (20),
    .ERR_CNT_W       (8)
  ) dut (
    .sdram_clk    (clk),
    .sdram_resetn (resetn),
    .sdram_en     (en),
    .sdram_cs_n   (cs_n),
    .sdram_ras_n  (ras_n),
    .sdram_cas_n  (cas_n),
    .sdram_we_n   (we_n),
    .init_done    (init_done),
    .init_err     (init_err),
    .ref_err      (ref_err),
    .err_code     (err_code),
    .err_count    (err_count),
    .mon_state    (mon_state)
  );

  sdram_init_monitor #(
    .INIT_NOP_CYCLES (8),
    .NUM_AREF        (2),
    .REF_INTERVAL    (20),
    .ERR_CNT_W       (2)
  ) dut_sat (
    .sdram_clk    (clk),
    .sdram_resetn (resetn),
    .sdram_en     (en),
    .sdram_cs_n   (cs_n),
    .sdram_ras_n  (ras_n),
    .sdram_cas_n  (cas_n),
    .sdram_we_n   (we_n),
    .init_done    (s_done),
    .init_err     (s_ierr),
    .ref_err      (s_rerr),
    .err_code     (s_code),
    .err_count    (s_count),
    .mon_state    (s_state)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic tick(input logic [3:0] c);
    {cs_n, ras_n, cas_n, we_n} = c;
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input logic [3:0] c, input int n);
    for (int i = 0; i < n; i++) tick(c);
  endtask

  // en low one cycle (arms/returns to IDLE), then rise into WAIT.
  task automatic start_init();
    en = 1'b0;
    tick(NOP);
    chk("idle_after_en_low", 32'(mon_state), 32'd0);
    en = 1'b1;
    tick(NOP);
    chk("wait_after_rise", 32'(mon_state), 32'd1);
  endtask

  task automatic legal_init();
    start_init();
    ticks(NOP, 7);
    chk("wait_after_7_nop", 32'(mon_state), 32'd1);
    tick(NOP);
    chk("pre_after_8_nop", 32'(mon_state), 32'd2);
    tick(PRE);
    chk("aref_after_pre", 32'(mon_state), 32'd3);
    ticks(NOP, 2);
    tick(AREF);
    chk("aref_after_1st", 32'(mon_state), 32'd3);
    ticks(NOP, 3);
    tick(AREF);
    chk("mrs_after_2nd", 32'(mon_state), 32'd4);
    chk("done_low_in_mrs", 32'(init_done), 32'd0);
    tick(LMR);
    chk("done_state", 32'(mon_state), 32'd5);
    chk("init_done", 32'(init_done), 32'd1);
    chk("legal_err_count", 32'(err_count), 32'(exp_cnt));
  endtask

  initial begin
    resetn = 1'b0;
    en     = 1'b0;
    {cs_n, ras_n, cas_n, we_n} = INH;
    #12;
    chk("rst_state", 32'(mon_state), 32'd0);
    chk("rst_done", 32'(init_done), 32'd0);
    chk("rst_ierr", 32'(init_err), 32'd0);
    chk("rst_cnt", 32'(err_count), 32'd0);
    resetn = 1'b1;

    // Legal sequence, then post-init behaviour.
    legal_init();
`ifdef SDRAM_MON_REF_WDOG_EN
    ticks(NOP, 19);
    chk("wdog_quiet_19", 32'(ref_err), 32'd0);
    tick(NOP);
    exp_cnt++;
    chk("wdog_ref_err", 32'(ref_err), 32'd1);
    chk("wdog_code", 32'(err_code), 32'd5);
    chk("wdog_count", 32'(err_count), 32'(exp_cnt));
    ticks(NOP, 18);
    tick(AREF);
    tick(NOP);
    chk("wdog_aref_count", 32'(err_count), 32'(exp_cnt));
    chk("wdog_aref_state", 32'(mon_state), 32'd5);
`else
    ticks(NOP, 20);
    chk("no_wdog_ref_err", 32'(ref_err), 32'd0);
    chk("no_wdog_code", 32'(err_code), 32'd0);
    chk("no_wdog_state", 32'(mon_state), 32'd5);
`endif
    en = 1'b0;
    tick(NOP);
    chk("en_low_idle", 32'(mon_state), 32'd0);
    chk("en_low_done", 32'(init_done), 32'd0);

    // Early precharge in WAIT.
    start_init();
    ticks(NOP, 4);
    tick(PRE);
    exp_cnt++;
    chk("early_pre_state", 32'(mon_state), 32'd6);
    chk("early_pre_code", 32'(err_code), 32'd1);
    chk("early_pre_ierr", 32'(init_err), 32'd1);
    chk("early_pre_count", 32'(err_count), 32'(exp_cnt));
    tick(NOP);
    chk("err_persists", 32'(mon_state), 32'd6);

    // Missing second refresh.
    start_init();
    ticks(NOP, 8);
    tick(PRE);
    tick(AREF);
    tick(LMR);
    exp_cnt++;
    chk("miss_aref_state", 32'(mon_state), 32'd6);
    chk("miss_aref_code", 32'(err_code), 32'd3);
    en = 1'b0;
    tick(NOP);
    chk("miss_aref_idle", 32'(mon_state), 32'd0);
    chk("miss_aref_ierr_held", 32'(init_err), 32'd1);
    chk("miss_aref_cnt_held", 32'(err_count), 32'(exp_cnt));

    // Asynchronous reset while in AREF.
    start_init();
    ticks(NOP, 8);
    tick(PRE);
    tick(AREF);
    chk("pre_rst_aref", 32'(mon_state), 32'd3);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_state", 32'(mon_state), 32'd0);
    chk("async_rst_ierr", 32'(init_err), 32'd0);
    chk("async_rst_code", 32'(err_code), 32'd0);
    chk("async_rst_cnt", 32'(err_count), 32'd0);
    chk("async_rst_done", 32'(init_done), 32'd0);
    chk("async_rst_rerr", 32'(ref_err), 32'd0);
    exp_cnt = 0;
    en = 1'b1;
    #2 resetn = 1'b1;
    // en already high at release must not count as a rising edge.
    ticks(NOP, 2);
    chk("no_rise_after_rst", 32'(mon_state), 32'd0);
    legal_init();

    // Five forced errors: 8-bit counter tracks, 2-bit counter saturates.
    for (int i = 0; i < 5; i++) begin
      start_init();
      tick(RD);
      exp_cnt++;
    end
    chk("forced_count", 32'(err_count), 32'(exp_cnt));
    chk("sat_count", 32'(s_count), 32'd3);
    chk("sat_state", 32'(s_state), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
